// File: rtl/vedic_mac_pipe.sv
// Pipelined unsigned multiply-accumulate built on a Vedic half-split multiplier.
// Optional build macro MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module vedic_mac_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_cnt,
  output logic                 out_ovf
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned PW   = 2 * WIDTH;

  logic w_stall;

  logic [HALF-1:0]  w_a_lo, w_a_hi, w_b_lo, w_b_hi;
  logic [WIDTH-1:0] w_pp_ll, w_pp_hl, w_pp_lh, w_pp_hh;

  logic             r_s1_valid, r_s1_last;
  logic [WIDTH-1:0] r_pp_ll, r_pp_hl, r_pp_lh, r_pp_hh;

  logic [WIDTH:0]   w_mid;
  logic [PW-1:0]    w_prod;

  logic             r_s2_valid, r_s2_last;
  logic [PW-1:0]    r_s2_prod;

  logic [ACC_WIDTH-1:0] w_base, w_acc_next;
  logic [ACC_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_ovf_next;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic                 r_fresh;

  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_acc;
  logic [CNT_WIDTH-1:0] r_out_cnt;
  logic                 r_out_ovf;

  // A held result freezes the whole pipe, so nothing downstream of S1 can be overwritten.
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;

  assign w_a_lo = in_a[HALF-1:0];
  assign w_a_hi = in_a[WIDTH-1:HALF];
  assign w_b_lo = in_b[HALF-1:0];
  assign w_b_hi = in_b[WIDTH-1:HALF];

  assign w_pp_ll = {{HALF{1'b0}}, w_a_lo} * {{HALF{1'b0}}, w_b_lo};
  assign w_pp_hl = {{HALF{1'b0}}, w_a_hi} * {{HALF{1'b0}}, w_b_lo};
  assign w_pp_lh = {{HALF{1'b0}}, w_a_lo} * {{HALF{1'b0}}, w_b_hi};
  assign w_pp_hh = {{HALF{1'b0}}, w_a_hi} * {{HALF{1'b0}}, w_b_hi};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_pp_ll    <= '0;
      r_pp_hl    <= '0;
      r_pp_lh    <= '0;
      r_pp_hh    <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_last;
      r_pp_ll    <= w_pp_ll;
      r_pp_hl    <= w_pp_hl;
      r_pp_lh    <= w_pp_lh;
      r_pp_hh    <= w_pp_hh;
    end
  end

  // Cross terms are summed one bit wider before shifting so the carry is kept.
  assign w_mid  = {1'b0, r_pp_hl} + {1'b0, r_pp_lh};
  assign w_prod = {{WIDTH{1'b0}}, r_pp_ll}
                + ({{(WIDTH - 1){1'b0}}, w_mid} << HALF)
                + {r_pp_hh, {WIDTH{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_prod  <= w_prod;
    end
  end

  always_comb begin
    w_base     = r_fresh ? '0 : r_acc;
    w_sum      = {1'b0, w_base} + {{(ACC_WIDTH + 1 - PW){1'b0}}, r_s2_prod};
    w_ovf_next = (r_fresh ? 1'b0 : r_ovf) | w_sum[ACC_WIDTH];
    w_cnt_next = r_fresh ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);
`ifdef MAC_SATURATE_EN
    // The sticky flag keeps the clamp in force until the result closes.
    w_acc_next = w_ovf_next ? '1 : w_sum[ACC_WIDTH-1:0];
`else
    w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_fresh     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      if (r_s2_valid) begin
        r_acc   <= w_acc_next;
        r_cnt   <= w_cnt_next;
        r_ovf   <= w_ovf_next;
        r_fresh <= r_s2_last;
      end
      // Not stalled means any held result is being taken this edge.
      r_out_valid <= r_s2_valid && r_s2_last;
      if (r_s2_valid && r_s2_last) begin
        r_out_acc <= w_acc_next;
        r_out_cnt <= w_cnt_next;
        r_out_ovf <= w_ovf_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_cnt   = r_out_cnt;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_vedic_mac_pipe.sv
// Directed and randomized-handshake bench for vedic_mac_pipe at three configurations
// sharing one stimulus stream: 8x8/24-bit, 4x4/16-bit and 8x8/16-bit (overflow).
module tb_vedic_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_a, in_b;

  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0]  out_cnt;

  logic        rdy4, vld4, ovf4;
  logic [15:0] acc4;
  logic [7:0]  cnt4;

  logic        rdy16, vld16, ovf16;
  logic [15:0] acc16;
  logic [7:0]  cnt16;

  int total = 0;
  int bad   = 0;
  bit mon_done;

  always #5 clk = ~clk;

  vedic_mac_pipe #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  vedic_mac_pipe #(.WIDTH(4), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_a(in_a[3:0]),
    .in_b(in_b[3:0]), .in_last(in_last), .out_valid(vld4), .out_ready(out_ready),
    .out_acc(acc4), .out_cnt(cnt4), .out_ovf(ovf4)
  );

  vedic_mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(vld16), .out_ready(out_ready), .out_acc(acc16),
    .out_cnt(cnt16), .out_ovf(ovf16)
  );

  // Presents one term and returns just after the edge that accepts it; in_valid is left high.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready got=%0b want=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
  endtask

  // Called at a negedge: accept the held result on the next edge.
  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
    if (out_acc !== 24'd0) begin bad++; $display("FAIL rst_acc got=%0d want=0", out_acc); end
    if (out_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", out_cnt); end
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b want=0", out_ovf); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_w4();
    send(8'd15, 8'd15, 1'b1);
    idle();
    @(negedge clk);
    total++;
    if (vld4 !== 1'b0) begin bad++; $display("FAIL lat_edge1 valid got=%0b want=0", vld4); end
    @(negedge clk);
    total++;
    if (vld4 !== 1'b0) begin bad++; $display("FAIL lat_edge2 valid got=%0b want=0", vld4); end
    @(negedge clk);
    total += 5;
    if (vld4 !== 1'b1) begin bad++; $display("FAIL lat_edge3 valid got=%0b want=1", vld4); end
    if (acc4 !== 16'd225) begin bad++; $display("FAIL w4_acc got=%0d want=225", acc4); end
    if (cnt4 !== 8'd1) begin bad++; $display("FAIL w4_cnt got=%0d want=1", cnt4); end
    if (ovf4 !== 1'b0) begin bad++; $display("FAIL w4_ovf got=%0b want=0", ovf4); end
    if (out_acc !== 24'd225) begin bad++; $display("FAIL w8_single got=%0d want=225", out_acc); end
    pop();
  endtask

  task automatic test_back_to_back();
    bit ok;
    send(8'd3, 8'd4, 1'b0);
    send(8'd10, 8'd20, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    idle();
    wait_out(ok);
    total += 3;
    if (!ok || out_acc !== 24'd65237) begin bad++; $display("FAIL b2b_acc got=%0d want=65237", out_acc); end
    if (out_cnt !== 8'd3) begin bad++; $display("FAIL b2b_cnt got=%0d want=3", out_cnt); end
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%0b want=0", out_ovf); end
    pop();
    send(8'd2, 8'd2, 1'b1);
    idle();
    wait_out(ok);
    total += 2;
    if (!ok || out_acc !== 24'd4) begin bad++; $display("FAIL b2b_fresh_acc got=%0d want=4", out_acc); end
    if (out_cnt !== 8'd1) begin bad++; $display("FAIL b2b_fresh_cnt got=%0d want=1", out_cnt); end
    pop();
  endtask

  task automatic test_stall();
    bit ok;
    send(8'd1, 8'd2, 1'b1);
    send(8'd3, 8'd3, 1'b0);
    send(8'd4, 8'd4, 1'b0);
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total += 4;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%0b want=0", i, in_ready); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%0b want=1", i, out_valid); end
      if (out_acc !== 24'd2) begin bad++; $display("FAIL stall_acc[%0d] got=%0d want=2", i, out_acc); end
      if (out_cnt !== 8'd1) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d want=1", i, out_cnt); end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL unstall_ready got=%0b want=1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle();
    wait_out(ok);
    total += 2;
    if (!ok || out_acc !== 24'd50) begin bad++; $display("FAIL resume_acc got=%0d want=50", out_acc); end
    if (out_cnt !== 8'd3) begin bad++; $display("FAIL resume_cnt got=%0d want=3", out_cnt); end
    pop();
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(8'd5, 8'd5, 1'b0);
    send(8'd7, 8'd7, 1'b1);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total += 4;
    if (out_acc !== 24'd0) begin bad++; $display("FAIL midrst_acc got=%0d want=0", out_acc); end
    if (out_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", out_cnt); end
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%0b want=0", out_ovf); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b want=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d] got=%0b want=0", i, out_valid); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    send(8'd2, 8'd3, 1'b1);
    idle();
    wait_out(ok);
    total += 2;
    if (!ok || out_acc !== 24'd6) begin bad++; $display("FAIL postrst_acc got=%0d want=6", out_acc); end
    if (out_cnt !== 8'd1) begin bad++; $display("FAIL postrst_cnt got=%0d want=1", out_cnt); end
    pop();
  endtask

  task automatic test_overflow();
    bit ok;
    logic [15:0] want16;
`ifdef MAC_SATURATE_EN
    want16 = 16'd65535;
`else
    want16 = 16'd64514;
`endif
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    idle();
    wait_out(ok);
    total += 4;
    if (!ok || acc16 !== want16) begin bad++; $display("FAIL ovf16_acc got=%0d want=%0d", acc16, want16); end
    if (ovf16 !== 1'b1) begin bad++; $display("FAIL ovf16_flag got=%0b want=1", ovf16); end
    if (out_acc !== 24'd130050) begin bad++; $display("FAIL ovf24_acc got=%0d want=130050", out_acc); end
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL ovf24_flag got=%0b want=0", out_ovf); end
    pop();
    send(8'd1, 8'd1, 1'b1);
    idle();
    wait_out(ok);
    total += 2;
    if (!ok || acc16 !== 16'd1) begin bad++; $display("FAIL ovf_clear_acc got=%0d want=1", acc16); end
    if (ovf16 !== 1'b0) begin bad++; $display("FAIL ovf_clear_flag got=%0b want=0", ovf16); end
    pop();
  endtask

  task automatic test_bubble();
    bit ok;
    send(8'd2, 8'd3, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    send(8'd4, 8'd5, 1'b1);
    idle();
    wait_out(ok);
    total += 2;
    if (!ok || out_acc !== 24'd26) begin bad++; $display("FAIL bubble_acc got=%0d want=26", out_acc); end
    if (out_cnt !== 8'd2) begin bad++; $display("FAIL bubble_cnt got=%0d want=2", out_cnt); end
    pop();
  endtask

  task automatic test_cnt_wrap();
    bit ok;
    for (int i = 0; i < 257; i++) send(8'd1, 8'd1, (i == 256));
    idle();
    wait_out(ok);
    total += 2;
    if (!ok || out_acc !== 24'd257) begin bad++; $display("FAIL wrap_acc got=%0d want=257", out_acc); end
    if (out_cnt !== 8'd1) begin bad++; $display("FAIL wrap_cnt got=%0d want=1", out_cnt); end
    pop();
  endtask

  task automatic test_random();
    int exp_acc[$];
    int exp_cnt[$];
    int got = 0;
    mon_done = 1'b0;
    fork
      begin
        for (int r = 0; r < 1000; r++) begin
          int n = $urandom_range(1, 4);
          int s = 0;
          for (int t = 0; t < n; t++) begin
            logic [7:0] a = 8'($urandom_range(0, 255));
            logic [7:0] b = 8'($urandom_range(0, 255));
            s += int'(a) * int'(b);
            if ($urandom_range(0, 3) == 0) begin
              idle();
              @(posedge clk); #1;
            end
            send(a, b, (t == n - 1));
          end
          exp_acc.push_back(s);
          exp_cnt.push_back(n);
        end
        idle();
      end
      begin
        while (!mon_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
      end
      begin
        int cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            int ea = (exp_acc.size() > 0) ? exp_acc.pop_front() : -1;
            int ec = (exp_cnt.size() > 0) ? exp_cnt.pop_front() : -1;
            total += 2;
            if (out_acc !== 24'(ea)) begin
              bad++; $display("FAIL rnd_acc[%0d] got=%0d want=%0d", got, out_acc, ea);
            end
            if (out_cnt !== 8'(ec)) begin
              bad++; $display("FAIL rnd_cnt[%0d] got=%0d want=%0d", got, out_cnt, ec);
            end
            got++;
          end
        end
        total++;
        if (got != 1000) begin bad++; $display("FAIL rnd_results got=%0d want=1000", got); end
        mon_done = 1'b1;
      end
    join
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_w4();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_overflow();
    test_bubble();
    test_cnt_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
